// File: rtl/unisim_sram_bank_1w1r.sv
// unisim_sram_bank_1w1r
//   Parametrised 1-write/1-read SRAM wrapper built from 2048x8 block RAM
//   primitives. The logical WORDS x DBITS memory is split into vertical
//   banks (upper address bits) and 8-bit horizontal slices. Adds write-to-read
//   forwarding on same-address collision, a read-valid pipeline and
//   out-of-range detection.
//   Optional macro UNISIM_SRAM_OUTREG_EN adds an output register stage after
//   the merge mux (read latency 2 instead of 1).

// Behavioural model of one 2048x8 primitive: port 0 writes, port 1 reads.
// Port 1 returns the pre-write contents on a same-address collision
// (READ_FIRST), and its output holds while port 1 is idle.
module unisim_bram_2048x8 #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          CE0,
    input  logic          WE0,
    input  logic [AW-1:0] A0,
    input  logic [DW-1:0] D0,
    input  logic [DW-1:0] WEM0,
    input  logic          CE1,
    input  logic [AW-1:0] A1,
    output logic [DW-1:0] Q1
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_q;

    // Bit-masked write through port 0.
    always_ff @(posedge CLK) begin
        if (CE0 && WE0) begin
            r_mem[A0] <= (D0 & WEM0) | (r_mem[A0] & ~WEM0);
        end
    end

    // Registered read through port 1; output holds when not enabled.
    always_ff @(posedge CLK) begin
        if (CE1) begin
            r_q <= r_mem[A1];
        end
    end

    assign Q1 = r_q;
endmodule

module unisim_sram_bank_1w1r #(
    parameter int ABITS      = 7,
    parameter int DBITS      = 8,
    parameter int WORDS      = 128,
    parameter int BANK_ABITS = 11,
    parameter int BANK_DBITS = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CE0,
    input  logic [ABITS-1:0] A0,
    input  logic [DBITS-1:0] D0,
    input  logic             WE0,
    input  logic [DBITS-1:0] WEM0,
    input  logic             CE1,
    input  logic [ABITS-1:0] A1,
    output logic [DBITS-1:0] Q1,
    output logic             Q1_VALID,
    output logic             OOR_ERR
);
    localparam int HB   = (DBITS + BANK_DBITS - 1) / BANK_DBITS;
    localparam int VB   = (ABITS <= BANK_ABITS) ? 1
                        : (WORDS + (1 << BANK_ABITS) - 1) / (1 << BANK_ABITS);
    localparam int PW   = HB * BANK_DBITS;
    localparam int SELW = (ABITS > BANK_ABITS) ? (ABITS - BANK_ABITS) : 1;
    localparam int INW  = (ABITS < BANK_ABITS) ? ABITS : BANK_ABITS;
    localparam logic [ABITS:0] WORDS_W = (ABITS+1)'(WORDS);

    // Address decode results
    logic [BANK_ABITS-1:0] w_a0_in;
    logic [BANK_ABITS-1:0] w_a1_in;
    logic [SELW-1:0]       w_a0_sel;
    logic [SELW-1:0]       w_a1_sel;
    logic                  w_a0_ok;
    logic                  w_a1_ok;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_col;
    logic [PW-1:0]         w_d0_pad;
    logic [PW-1:0]         w_m0_pad;
    logic [VB-1:0]         w_bwe;
    logic [VB-1:0]         w_bre;
    logic [VB-1:0][PW-1:0] w_bank_q;
    logic [PW-1:0]         w_raw_pad;
    logic [DBITS-1:0]      w_raw;
    logic [DBITS-1:0]      w_merge;
    logic                  w_unused;

    // Read-side pipeline state
    logic [SELW-1:0]  r_sel;
    logic             r_rd_ok;
    logic             r_vld1;
    logic             r_fwd_hit;
    logic [DBITS-1:0] r_fwd_d;
    logic [DBITS-1:0] r_fwd_m;
    logic             r_oor;

    // Bank index comes from the upper address bits only when the logical
    // address is wider than one primitive; otherwise there is a single bank.
    if (ABITS > BANK_ABITS) begin : g_sel
        assign w_a0_sel = A0[ABITS-1:BANK_ABITS];
        assign w_a1_sel = A1[ABITS-1:BANK_ABITS];
    end else begin : g_nosel
        assign w_a0_sel = 1'b0;
        assign w_a1_sel = 1'b0;
    end

    // In-bank addresses, range checks and zero-padded write data/mask.
    always_comb begin
        w_a0_in = '0;
        w_a1_in = '0;
        w_a0_in[INW-1:0] = A0[INW-1:0];
        w_a1_in[INW-1:0] = A1[INW-1:0];
        w_a0_ok = ({1'b0, A0} < WORDS_W);
        w_a1_ok = ({1'b0, A1} < WORDS_W);
        w_d0_pad = '0;
        w_m0_pad = '0;
        w_d0_pad[DBITS-1:0] = D0;
        w_m0_pad[DBITS-1:0] = WEM0;
    end

    // Bank enables are held low during reset so memory contents survive it.
    assign w_wr_en = RSTN & CE0 & WE0 & w_a0_ok;
    assign w_rd_en = RSTN & CE1 & w_a1_ok;
    assign w_col   = CE0 & WE0 & CE1 & w_a0_ok & (A0 == A1);

    for (genvar b = 0; b < VB; b++) begin : g_bank
        assign w_bwe[b] = w_wr_en & (w_a0_sel == SELW'(b));
        assign w_bre[b] = w_rd_en & (w_a1_sel == SELW'(b));
        for (genvar h = 0; h < HB; h++) begin : g_slice
            unisim_bram_2048x8 #(
                .AW (BANK_ABITS),
                .DW (BANK_DBITS)
            ) u_bram (
                .CLK  (CLK),
                .CE0  (w_bwe[b]),
                .WE0  (w_bwe[b]),
                .A0   (w_a0_in),
                .D0   (w_d0_pad[h*BANK_DBITS +: BANK_DBITS]),
                .WEM0 (w_m0_pad[h*BANK_DBITS +: BANK_DBITS] & {BANK_DBITS{w_bwe[b]}}),
                .CE1  (w_bre[b]),
                .A1   (w_a1_in),
                .Q1   (w_bank_q[b][h*BANK_DBITS +: BANK_DBITS])
            );
        end
    end

    // Pick the bank captured with the read, then merge any forwarded write.
    always_comb begin
        w_raw_pad = '0;
        for (int b = 0; b < VB; b++) begin
            w_raw_pad = (r_sel == SELW'(b)) ? w_bank_q[b] : w_raw_pad;
        end
        w_raw = w_raw_pad[DBITS-1:0];
        if (!r_rd_ok) begin
            w_merge = '0;
        end else if (r_fwd_hit) begin
            w_merge = (r_fwd_d & r_fwd_m) | (w_raw & ~r_fwd_m);
        end else begin
            w_merge = w_raw;
        end
    end

    // Padding bits of the top slice are never returned.
    assign w_unused = ^w_raw_pad;

    // Read bookkeeping: bank select, range flag, valid, forwarding, OOR pulse.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_sel     <= '0;
            r_rd_ok   <= 1'b0;
            r_vld1    <= 1'b0;
            r_fwd_hit <= 1'b0;
            r_fwd_d   <= '0;
            r_fwd_m   <= '0;
            r_oor     <= 1'b0;
        end else begin
            if (CE1) begin
                r_sel   <= w_a1_sel;
                r_rd_ok <= w_a1_ok;
            end
            r_vld1    <= CE1;
            r_fwd_hit <= w_col;
            if (w_col) begin
                r_fwd_d <= D0;
                r_fwd_m <= WEM0;
            end
            r_oor <= (CE0 & WE0 & ~w_a0_ok) | (CE1 & ~w_a1_ok);
        end
    end

    assign OOR_ERR = r_oor;

`ifdef UNISIM_SRAM_OUTREG_EN
    logic [DBITS-1:0] r_q_out;
    logic             r_vld2;

    // Output stage: capture the merged word only when a read completes.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_q_out <= '0;
            r_vld2  <= 1'b0;
        end else begin
            if (r_vld1) begin
                r_q_out <= w_merge;
            end
            r_vld2 <= r_vld1;
        end
    end

    assign Q1       = r_q_out;
    assign Q1_VALID = r_vld2;
`else
    logic [DBITS-1:0] r_q_hold;

    // Remember the last presented word so Q1 holds between reads.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_q_hold <= '0;
        end else begin
            r_q_hold <= Q1;
        end
    end

    assign Q1       = r_vld1 ? w_merge : r_q_hold;
    assign Q1_VALID = r_vld1;
`endif

endmodule

// File: tb/tb_unisim_sram_bank_1w1r.sv
// Bench for unisim_sram_bank_1w1r: 32-bit x 6000-word geometry (3 banks x 4
// slices). A reference memory and a queue of pending read results predict
// Q1, Q1_VALID and OOR_ERR after every clock edge.
module tb_unisim_sram_bank_1w1r;
    localparam int ABITS = 13;
    localparam int DBITS = 32;
    localparam int WORDS = 6000;
`ifdef UNISIM_SRAM_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    typedef struct {
        int          due;
        logic [31:0] val;
    } rd_t;

    logic             clk = 1'b0;
    logic             RSTN = 1'b0;
    logic             CE0 = 1'b0;
    logic [ABITS-1:0] A0 = '0;
    logic [DBITS-1:0] D0 = '0;
    logic             WE0 = 1'b0;
    logic [DBITS-1:0] WEM0 = '0;
    logic             CE1 = 1'b0;
    logic [ABITS-1:0] A1 = '0;
    logic [DBITS-1:0] Q1;
    logic             Q1_VALID;
    logic             OOR_ERR;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem [int];
    rd_t         pend [$];
    logic [31:0] last_q = 32'h0;

    unisim_sram_bank_1w1r #(
        .ABITS (ABITS),
        .DBITS (DBITS),
        .WORDS (WORDS)
    ) dut (
        .CLK      (clk),
        .RSTN     (RSTN),
        .CE0      (CE0),
        .A0       (A0),
        .D0       (D0),
        .WE0      (WE0),
        .WEM0     (WEM0),
        .CE1      (CE1),
        .A1       (A1),
        .Q1       (Q1),
        .Q1_VALID (Q1_VALID),
        .OOR_ERR  (OOR_ERR)
    );

    always #5 clk = ~clk;

    // One clock cycle: apply inputs, predict, clock, then compare outputs.
    task automatic op(input bit rst, input bit ce0, input bit we0, input int a0,
                      input logic [31:0] d0, input logic [31:0] m0,
                      input bit ce1, input int a1, input string tag);
        logic [31:0] v;
        logic [31:0] old;
        logic [31:0] exp_q;
        logic        exp_v;
        logic        exp_oor;
        RSTN = rst ? 1'b0 : 1'b1;
        CE0  = ce0;
        WE0  = we0;
        A0   = 13'(a0);
        D0   = d0;
        WEM0 = m0;
        CE1  = ce1;
        A1   = 13'(a1);
        exp_oor = !rst && ((ce0 && we0 && a0 >= WORDS) || (ce1 && a1 >= WORDS));
        if (rst) begin
            pend.delete();
            last_q = 32'h0;
        end else begin
            if (ce1) begin
                if (a1 >= WORDS) begin
                    v = 32'h0;
                end else begin
                    v = mem.exists(a1) ? mem[a1] : 32'h0;
                    if (ce0 && we0 && a0 == a1) v = (d0 & m0) | (v & ~m0);
                end
                pend.push_back('{cyc + RD_LAT, v});
            end
            if (ce0 && we0 && a0 < WORDS) begin
                old = mem.exists(a0) ? mem[a0] : 32'h0;
                mem[a0] = (d0 & m0) | (old & ~m0);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_v  = 1'b1;
            exp_q  = pend[0].val;
            last_q = exp_q;
            void'(pend.pop_front());
        end else begin
            exp_v = 1'b0;
            exp_q = last_q;
        end
        checks++;
        assert (Q1_VALID === exp_v) else begin
            errors++;
            $error("FAIL %s.valid cyc %0d got %b exp %b", tag, cyc, Q1_VALID, exp_v);
        end
        checks++;
        assert (Q1 === exp_q) else begin
            errors++;
            $error("FAIL %s.q1 cyc %0d got %h exp %h", tag, cyc, Q1, exp_q);
        end
        checks++;
        assert (OOR_ERR === exp_oor) else begin
            errors++;
            $error("FAIL %s.oor cyc %0d got %b exp %b", tag, cyc, OOR_ERR, exp_oor);
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [31:0] m, input string tag);
        op(1'b0, 1'b1, 1'b1, a, d, m, 1'b0, 0, tag);
    endtask

    task automatic rd(input int a, input string tag);
        op(1'b0, 1'b0, 1'b0, 0, 32'h0, 32'h0, 1'b1, a, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 1'b0, 0, 32'h0, 32'h0, 1'b0, 0, tag);
    endtask

    initial begin
        // Reset with a read request held high: everything stays quiet.
        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 1'b0, 0, 32'h0, 32'h0, 1'b1, 0, "reset");

        // Basic: one word per bank plus a bystander in bank 2.
        wr(32'h1000, 32'h0BADF00D, 32'hFFFFFFFF, "pre_bank2");
        wr(32'h0000, 32'hDEADBEEF, 32'hFFFFFFFF, "wr_bank0");
        wr(32'h0800, 32'h12345678, 32'hFFFFFFFF, "wr_bank1");
        wr(32'h1700, 32'hCAFEF00D, 32'hFFFFFFFF, "wr_bank2");
        rd(32'h0000, "rd_bank0");
        rd(32'h0800, "rd_bank1");
        rd(32'h1700, "rd_bank2");
        rd(32'h1000, "rd_bystander");
        idle(3, "basic_hold");

        // Bit mask.
        wr(5, 32'hFFFFFFFF, 32'hFFFFFFFF, "mask_pre");
        wr(5, 32'h00000000, 32'h0000FF00, "mask_wr");
        rd(5, "mask_rd");
        idle(2, "mask_hold");

        // Collision forwarding, then a plain re-read.
        wr(9, 32'hAAAAAAAA, 32'hFFFFFFFF, "col_pre");
        op(1'b0, 1'b1, 1'b1, 9, 32'h55555555, 32'hFFFF0000, 1'b1, 9, "col_same");
        rd(9, "col_after");
        idle(2, "col_hold");

        // Out of range on both ports, last legal word, top of address space.
        wr(5999, 32'h600DCAFE, 32'hFFFFFFFF, "oor_pre");
        wr(6000, 32'h11111111, 32'hFFFFFFFF, "oor_wr");
        idle(1, "oor_gap");
        rd(6000, "oor_rd");
        idle(1, "oor_gap2");
        rd(5999, "oor_last");
        rd(8191, "oor_top");
        idle(2, "oor_hold");

        // A read issued right before reset must never show as valid.
        rd(0, "flight_rd");
        op(1'b1, 1'b0, 1'b0, 0, 32'h0, 32'h0, 1'b0, 0, "flight_rst");
        idle(3, "flight_after");

        // Back-to-back: 64 writes then 64 consecutive reads.
        for (int i = 0; i < 64; i++) wr(i, 32'(i), 32'hFFFFFFFF, "b2b_wr");
        for (int i = 0; i < 64; i++) rd(i, "b2b_rd");
        idle(3, "b2b_tail");

        // Randomized mix with biased collisions and out-of-range accesses.
        for (int i = 0; i < 300; i++) begin
            bit          ce0;
            bit          we0;
            bit          ce1;
            int          a0;
            int          a1;
            logic [31:0] d;
            logic [31:0] m;
            ce0 = ($urandom_range(0, 3) != 0);
            we0 = ($urandom_range(0, 4) != 0);
            ce1 = ($urandom_range(0, 3) != 0);
            a0  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(6000, 8191)) : int'($urandom_range(0, 63));
            a1  = ($urandom_range(0, 3) == 0) ? a0
                : (($urandom_range(0, 15) == 0) ? int'($urandom_range(6000, 8191)) : int'($urandom_range(0, 63)));
            d   = $urandom;
            m   = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF : 32'($urandom);
            op(1'b0, ce0, we0, a0, d, m, ce1, a1, "random");
        end
        idle(3, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unisim_sram_bank_1w1r.md
Name: unisim_sram_bank_1w1r

Overview:
- Parametrised 1-write/1-read SRAM wrapper for the unisim techmap layer. Supersedes the fixed-geometry per-size generated wrappers.
- Tiles a logical WORDS x DBITS memory onto an array of BRAM_2048x8 primitives:
  - vertical banks selected by the upper address bits;
  - horizontal slices of 8 bits each.
- Adds behaviour the generated wrappers lack:
  - write-to-read forwarding on address collision;
  - a read-valid pipeline;
  - out-of-range detection;
  - an optional output register stage.

Parameters:
- ABITS, 7, logical address width.
- DBITS, 8, logical data width (1..64); the top slice is zero-padded.
- WORDS, 128, logical depth (<= 2^ABITS); not required to be a power of two.
- BANK_ABITS, 11, address width of one primitive (2048 words).
- BANK_DBITS, 8, data width of one primitive.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RSTN  in  1  synchronous, active-low reset.
- CE0  in  1  write-port enable.
- A0  in  ABITS  write address.
- D0  in  DBITS  write data.
- WE0  in  1  write enable (effective only with CE0=1).
- WEM0  in  DBITS  per-bit write mask; 1 = bit written.
- CE1  in  1  read-port enable.
- A1  in  ABITS  read address.
- Q1  out  DBITS  read data.
- Q1_VALID  out  1  Q1 holds the result of a read issued RD_LAT cycles earlier.
- OOR_ERR  out  1  one-cycle pulse, registered: the previous cycle presented an out-of-range access on either port.

Behaviour:
- Geometry:
  - HB = ceil(DBITS/BANK_DBITS) horizontal slices.
  - VB = ceil(WORDS/2^BANK_ABITS) vertical banks; VB=1 when ABITS <= BANK_ABITS.
  - Bank index = A[ABITS-1:BANK_ABITS].
  - In-bank address = A[min(ABITS,BANK_ABITS)-1:0], zero-extended to BANK_ABITS.
- Port mapping: write port drives primitive port 0 only; read port drives primitive port 1 only. Primitives are configured READ_FIRST.
- Write path:
  - CE0&WE0 with A0<WORDS: only the addressed vertical bank receives CE=1; all its slices get their D0/WEM0 segment.
  - Non-addressed banks see CE=0, WE=0, WEM=0.
  - A0>=WORDS: write dropped (no bank enabled); OOR_ERR=1 next cycle.
- Read path:
  - CE1 with A1<WORDS enables the addressed bank. The bank index is registered (sel_q).
  - Without OUT_REG: Q1 = slice-concatenated bank_Q[sel_q] in the cycle after CE1, truncated to DBITS.
  - A1>=WORDS: no bank enabled; Q1=0 at the normal data slot; Q1_VALID still asserted; OOR_ERR pulses.
- Collision forwarding:
  - Condition: CE0&WE0&CE1 and A0==A1 (in range) in the same cycle.
  - Register fwd_hit=1, fwd_d=D0, fwd_m=WEM0.
  - Returned data = (fwd_d & fwd_m) | (bank_Q & ~fwd_m), so the read sees the new data (write-first semantics).
  - fwd_hit clears on any cycle without collision.
- Q1_VALID:
  - Shift register of CE1, depth RD_LAT (1 without OUT_REG, 2 with).
  - Q1 holds its last value while Q1_VALID=0 (no bubbles forced to 0).
- Back-to-back: reads and writes accepted every cycle; no stall, no ready signal.
- Reset (RSTN=0 at a CLK edge):
  - Q1 = 0, Q1_VALID = 0, OOR_ERR = 0, sel_q = 0, fwd_hit = 0; output register cleared if present.
  - Bank CE/WE forced to 0 while RSTN=0; memory contents untouched.
  - A read in flight when reset asserts is discarded: no Q1_VALID after release.
- Simulation only (translate_off):
  - $display + $finish if VB*HB primitives are instantiated with DBITS > 64 or WORDS > 2^ABITS at elaboration.

Optional Feature:
- UNISIM_SRAM_OUTREG_EN defined:
  - Extra register after the merge/forward mux.
  - RD_LAT=2; Q1 and Q1_VALID both delayed one cycle.
  - The forward registers are pipelined alongside so the merge stays correct.
  - OOR_ERR timing unchanged.
- Undefined: RD_LAT=1; Q1 driven directly from the merge mux.

Test Plan:
- Reset: RSTN=0 for 3 cycles with CE1=1 -> Q1=0, Q1_VALID=0, OOR_ERR=0 throughout; first read after release gives Q1_VALID exactly RD_LAT cycles later.
- Basic, DBITS=32, ABITS=13, WORDS=6000 (3 vertical banks x 4 slices): write 0xDEADBEEF @0x0000, 0x12345678 @0x0800, 0xCAFEF00D @0x1700; read each -> exact values after RD_LAT; adjacent banks unaffected.
- Bit mask: preload 0xFFFFFFFF @5; write D0=0x00000000, WEM0=0x0000FF00 @5; read @5 -> 0xFFFF00FF.
- Collision: preload 0xAAAAAAAA @9; same cycle write D0=0x55555555, WEM0=0xFFFF0000 @9 and read @9 -> 0x5555AAAA; the following read @9 -> 0x5555AAAA.
- Out of range, WORDS=6000: write @6000 then read @6000 -> OOR_ERR pulses once per access; Q1=0 with Q1_VALID=1; read @5999 returns its preload unchanged.
- Back-to-back: 64 consecutive reads of addresses 0..63 after 64 writes of value=address -> Q1_VALID high 64 consecutive cycles, Q1=0..63 in order; repeat with UNISIM_SRAM_OUTREG_EN defined -> same sequence shifted by one cycle.
